// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter sharing one memory controller between I-side and D-side miss requests.
// One transaction at a time: IDLE (arbitrate) -> ISSUE (wait for free controller) -> WAIT (await block).
module mem_request_arbiter #(
  parameter int addressSize = 64,
  parameter int blockSize   = 256
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   iReq_i,
  input  logic [addressSize-1:0] iReqAddress_i,
  input  logic                   dReq_i,
  input  logic [addressSize-1:0] dReqAddress_i,
  input  logic                   dReqIsWrite_i,
  input  logic [blockSize-1:0]   dReqData_i,
  output logic [addressSize-1:0] address_o,
  output logic [blockSize-1:0]   data_o,
  output logic                   requestEnable_o,
  output logic                   isMemWrite_o,
  input  logic [blockSize-1:0]   block_i,
  input  logic [addressSize-1:0] blockAddress_i,
  input  logic                   blockOutEnable_i,
  input  logic                   isMemoryEngaged_i,
  output logic                   iGrant_o,
  output logic                   dGrant_o,
  output logic                   iBlockValid_o,
  output logic                   dBlockValid_o,
  output logic [blockSize-1:0]   respBlock_o,
  output logic [addressSize-1:0] respAddress_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, nextState;
  logic   lastServedD;
  logic   winnerD;
  logic   anyReq;
  logic   winD;

  always_comb begin
    anyReq    = iReq_i | dReq_i;
    // D wins when it is the only requester, or on a tie when I was served last
    winD      = dReq_i & ~(iReq_i & lastServedD);
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   if (!isMemoryEngaged_i) nextState = WAIT;
      WAIT:    if (blockOutEnable_i) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    requestEnable_o = (state == ISSUE) && !isMemoryEngaged_i;
    busy_o          = (state != IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= nextState;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lastServedD   <= 1'b1;
      winnerD       <= 1'b0;
      address_o     <= '0;
      data_o        <= '0;
      isMemWrite_o  <= 1'b0;
      iGrant_o      <= 1'b0;
      dGrant_o      <= 1'b0;
      iBlockValid_o <= 1'b0;
      dBlockValid_o <= 1'b0;
      respBlock_o   <= '0;
      respAddress_o <= '0;
    end else begin
      iGrant_o      <= 1'b0;
      dGrant_o      <= 1'b0;
      iBlockValid_o <= 1'b0;
      dBlockValid_o <= 1'b0;
      if (state == IDLE && anyReq) begin
        winnerD     <= winD;
        lastServedD <= winD;
        iGrant_o    <= ~winD;
        dGrant_o    <= winD;
        if (winD) begin
          address_o    <= dReqAddress_i;
          data_o       <= dReqData_i;
          isMemWrite_o <= dReqIsWrite_i;
        end else begin
          address_o    <= iReqAddress_i;
          data_o       <= '0;
          isMemWrite_o <= 1'b0;
        end
      end
      if (state == WAIT && blockOutEnable_i) begin
        respBlock_o   <= block_i;
        respAddress_o <= blockAddress_i;
        iBlockValid_o <= ~winnerD;
        dBlockValid_o <= winnerD;
      end
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized bench for mem_request_arbiter against a transaction-level model of
// round-robin arbitration, controller handshake and completion timing.
module tb_mem_request_arbiter;
  localparam int AW = 64;
  localparam int BW = 256;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          iReq_i;
  logic [AW-1:0] iReqAddress_i;
  logic          dReq_i;
  logic [AW-1:0] dReqAddress_i;
  logic          dReqIsWrite_i;
  logic [BW-1:0] dReqData_i;
  logic [AW-1:0] address_o;
  logic [BW-1:0] data_o;
  logic          requestEnable_o;
  logic          isMemWrite_o;
  logic [BW-1:0] block_i;
  logic [AW-1:0] blockAddress_i;
  logic          blockOutEnable_i;
  logic          isMemoryEngaged_i;
  logic          iGrant_o;
  logic          dGrant_o;
  logic          iBlockValid_o;
  logic          dBlockValid_o;
  logic [BW-1:0] respBlock_o;
  logic [AW-1:0] respAddress_o;
  logic          busy_o;

  mem_request_arbiter #(.addressSize(AW), .blockSize(BW)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .iReq_i(iReq_i), .iReqAddress_i(iReqAddress_i),
    .dReq_i(dReq_i), .dReqAddress_i(dReqAddress_i),
    .dReqIsWrite_i(dReqIsWrite_i), .dReqData_i(dReqData_i),
    .address_o(address_o), .data_o(data_o),
    .requestEnable_o(requestEnable_o), .isMemWrite_o(isMemWrite_o),
    .block_i(block_i), .blockAddress_i(blockAddress_i),
    .blockOutEnable_i(blockOutEnable_i), .isMemoryEngaged_i(isMemoryEngaged_i),
    .iGrant_o(iGrant_o), .dGrant_o(dGrant_o),
    .iBlockValid_o(iBlockValid_o), .dBlockValid_o(dBlockValid_o),
    .respBlock_o(respBlock_o), .respAddress_o(respAddress_o),
    .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int failures = 0;

  // reference state: who was served last (1 = D) and the last returned line
  bit            lastServedD;
  logic [BW-1:0] expResp;
  logic [AW-1:0] expRespAddr;

  task automatic checkVal(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [BW-1:0] rand256();
    logic [BW-1:0] r;
    for (int unsigned i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] randAddr();
    return {$urandom, $urandom};
  endfunction

  task automatic newI(input logic [AW-1:0] a);
    iReq_i = 1'b1;
    iReqAddress_i = a;
  endtask

  task automatic newD(input logic [AW-1:0] a, input logic [BW-1:0] d, input bit w);
    dReq_i = 1'b1;
    dReqAddress_i = a;
    dReqData_i = d;
    dReqIsWrite_i = w;
  endtask

  task automatic checkActive(input bit expD, input logic [AW-1:0] a, input logic [BW-1:0] d,
                             input bit w, input bit first, input bit expReqEn);
    checkVal("iGrant", 256'(iGrant_o), 256'(first && !expD));
    checkVal("dGrant", 256'(dGrant_o), 256'(first && expD));
    checkVal("requestEnable", 256'(requestEnable_o), 256'(expReqEn));
    checkVal("busy", 256'(busy_o), 256'(1'b1));
    checkVal("address", 256'(address_o), 256'(a));
    checkVal("data", data_o, d);
    checkVal("isMemWrite", 256'(isMemWrite_o), 256'(w));
    checkVal("iBlockValid", 256'(iBlockValid_o), 256'(1'b0));
    checkVal("dBlockValid", 256'(dBlockValid_o), 256'(1'b0));
  endtask

  // Runs one transaction from the arbitration cycle (requests already driven, DUT idle)
  // to the completion cycle, where the winner's request is dropped.
  task automatic serve(input int engaged, input int waitCyc, input bit dropWinner,
                       input logic [BW-1:0] rBlock, input logic [AW-1:0] rAddr, output bit wonD);
    bit            expD;
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    bit            w;
    if (iReq_i && dReq_i) expD = !lastServedD;
    else                  expD = dReq_i;
    if (expD) begin
      a = dReqAddress_i; d = dReqData_i; w = dReqIsWrite_i;
    end else begin
      a = iReqAddress_i; d = '0; w = 1'b0;
    end
    wonD = expD;
    #1;
    checkVal("busyIdle", 256'(busy_o), 256'(1'b0));
    checkVal("reqEnIdle", 256'(requestEnable_o), 256'(1'b0));
    tick();
    lastServedD = expD;
    if (dropWinner) begin
      if (expD) dReq_i = 1'b0;
      else      iReq_i = 1'b0;
    end
    for (int k = 0; k < engaged; k++) begin
      isMemoryEngaged_i = 1'b1;
      blockOutEnable_i = 1'($urandom_range(0, 1));
      block_i = rand256();
      #1;
      checkActive(expD, a, d, w, k == 0, 1'b0);
      tick();
    end
    isMemoryEngaged_i = 1'b0;
    blockOutEnable_i = 1'($urandom_range(0, 1));
    #1;
    checkActive(expD, a, d, w, engaged == 0, 1'b1);
    tick();
    for (int k = 0; k < waitCyc; k++) begin
      isMemoryEngaged_i = 1'($urandom_range(0, 1));
      blockOutEnable_i = 1'b0;
      #1;
      checkActive(expD, a, d, w, 1'b0, 1'b0);
      tick();
    end
    isMemoryEngaged_i = 1'b0;
    blockOutEnable_i = 1'b1;
    block_i = rBlock;
    blockAddress_i = rAddr;
    #1;
    checkActive(expD, a, d, w, 1'b0, 1'b0);
    tick();
    expResp = rBlock;
    expRespAddr = rAddr;
    blockOutEnable_i = 1'b0;
    block_i = rand256();
    blockAddress_i = randAddr();
    if (expD) dReq_i = 1'b0;
    else      iReq_i = 1'b0;
    #1;
    checkVal("iBlockValidDone", 256'(iBlockValid_o), 256'(!expD));
    checkVal("dBlockValidDone", 256'(dBlockValid_o), 256'(expD));
    checkVal("respBlock", respBlock_o, expResp);
    checkVal("respAddress", 256'(respAddress_o), 256'(expRespAddr));
    checkVal("busyDone", 256'(busy_o), 256'(1'b0));
    checkVal("grantDone", 256'({iGrant_o, dGrant_o}), 256'(2'b00));
  endtask

  task automatic checkAllZero(input string tag);
    checkVal(tag, 256'(address_o), 256'(0));
    checkVal(tag, data_o, '0);
    checkVal(tag, respBlock_o, '0);
    checkVal(tag, 256'(respAddress_o), 256'(0));
    checkVal(tag, 256'({iGrant_o, dGrant_o, iBlockValid_o, dBlockValid_o,
                        requestEnable_o, isMemWrite_o, busy_o}), 256'(0));
  endtask

  task automatic spuriousIdle();
    blockOutEnable_i = 1'b1;
    block_i = rand256();
    blockAddress_i = randAddr();
    tick();
    blockOutEnable_i = 1'b0;
    #1;
    checkVal("spuriousValid", 256'({iBlockValid_o, dBlockValid_o}), 256'(2'b00));
    checkVal("spuriousResp", respBlock_o, expResp);
    checkVal("spuriousRespAddr", 256'(respAddress_o), 256'(expRespAddr));
    checkVal("spuriousBusy", 256'(busy_o), 256'(1'b0));
  endtask

  initial begin
    bit wonD;
    reset_i = 1'b1;
    iReq_i = 1'b0; iReqAddress_i = '0;
    dReq_i = 1'b0; dReqAddress_i = '0; dReqIsWrite_i = 1'b0; dReqData_i = '0;
    block_i = '0; blockAddress_i = '0; blockOutEnable_i = 1'b0; isMemoryEngaged_i = 1'b0;
    lastServedD = 1'b1;
    expResp = '0;
    expRespAddr = '0;
    tick();
    tick();
    #1;
    checkAllZero("resetState");
    reset_i = 1'b0;
    tick();

    // tie held from reset: I first, then strict alternation
    newI(64'h100);
    newD(64'h200, rand256(), 1'b0);
    for (int k = 0; k < 4; k++) begin
      serve(0, 0, 1'b0, rand256(), randAddr(), wonD);
      checkVal("tieOrder", 256'(wonD), 256'(k % 2));
      if (wonD) newD(randAddr(), rand256(), 1'($urandom_range(0, 1)));
      else      newI(randAddr());
    end
    serve(0, 0, 1'b0, rand256(), randAddr(), wonD);
    iReq_i = 1'b0;
    dReq_i = 1'b0;
    tick();

    newI(64'h1000);
    serve(0, 1, 1'b0, {32{8'hAA}}, 64'h1000, wonD);
    checkVal("iOnlyWinner", 256'(wonD), 256'(1'b0));

    newD(64'h2000, {32{8'h55}}, 1'b1);
    serve(0, 2, 1'b0, rand256(), 64'h2000, wonD);
    checkVal("dWriteWinner", 256'(wonD), 256'(1'b1));

    newI(64'h3000);
    serve(5, 1, 1'b1, rand256(), randAddr(), wonD);

    spuriousIdle();

    // reset while waiting on the controller, then a stale block return
    newI(64'h4000);
    tick();
    isMemoryEngaged_i = 1'b0;
    tick();
    reset_i = 1'b1;
    blockOutEnable_i = 1'b1;
    iReq_i = 1'b0;
    tick();
    #1;
    checkAllZero("resetInWait");
    reset_i = 1'b0;
    lastServedD = 1'b1;
    expResp = '0;
    expRespAddr = '0;
    tick();
    #1;
    checkVal("staleValid", 256'({iBlockValid_o, dBlockValid_o}), 256'(2'b00));
    checkVal("staleResp", respBlock_o, '0);
    checkVal("staleBusy", 256'(busy_o), 256'(1'b0));
    blockOutEnable_i = 1'b0;
    tick();

    for (int n = 0; n < 200; n++) begin
      if (!iReq_i && $urandom_range(0, 1) == 1) newI(randAddr());
      if (!dReq_i && $urandom_range(0, 1) == 1) newD(randAddr(), rand256(), 1'($urandom_range(0, 1)));
      if (!iReq_i && !dReq_i) spuriousIdle();
      else serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                 rand256(), randAddr(), wonD);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
